// File: rtl/cpu_defs_pkg.sv
// Shared widths and ALU opcode encodings for the operand stage and its neighbours.
package cpu_defs;

  localparam int W   = 8;
  localparam int AW  = 3;
  localparam int OPW = 3;

  localparam logic [OPW-1:0] ALU_SHIFT = 3'b001;
  localparam logic [OPW-1:0] ALU_BNEG  = 3'b010;
  localparam logic [OPW-1:0] ALU_NOR   = 3'b011;
  // Any opcode with the top bit set decodes as an add.
  localparam logic [OPW-1:0] ALU_ADD   = 3'b100;

  function automatic logic is_add(input logic [OPW-1:0] op);
    return op[OPW-1];
  endfunction

endpackage

// File: rtl/operand_stage_reg_array.sv
// 2**AW x W register storage: two combinational read ports, one synchronous write
// port, whole array cleared by the asynchronous reset.
module reg_array
  import cpu_defs::*;
#(
  parameter int DW = W,
  parameter int DA = AW
) (
  input  logic          Clk_i,
  input  logic          Reset_i,
  input  logic          WriteEn_i,
  input  logic [DA-1:0] Waddr_i,
  input  logic [DW-1:0] DataIn_i,
  input  logic [DA-1:0] RaddrA_i,
  input  logic [DA-1:0] RaddrB_i,
  output logic [DW-1:0] RdataA_o,
  output logic [DW-1:0] RdataB_o
);

  localparam int N = 2 ** DA;

  logic [DW-1:0] mem_q [N];

  // Flop-based storage so the asynchronous clear reaches every entry.
  for (genvar gi = 0; gi < N; gi++) begin : g_reg
    always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
        mem_q[gi] <= '0;
      end else if (WriteEn_i && (Waddr_i == DA'(gi))) begin
        mem_q[gi] <= DataIn_i;
      end
    end
  end

  assign RdataA_o = mem_q[RaddrA_i];
  assign RdataB_o = mem_q[RaddrB_i];

endmodule

// File: rtl/operand_stage.sv
// ID/EX operand stage: register file read with write-through bypass, operand/opcode
// latch feeding the ALU one cycle later, and the architectural zero flag.
module operand_stage
  import cpu_defs::*;
#(
  parameter int DW  = W,
  parameter int DA  = AW,
  parameter int OW  = OPW
) (
  input  logic          Clk_i,
  input  logic          Reset_i,
  input  logic          Stall_i,
  input  logic          Flush_i,
  input  logic          InValid_i,
  input  logic [DA-1:0] RaddrA_i,
  input  logic [DA-1:0] RaddrB_i,
  input  logic [OW-1:0] OpIn_i,
  input  logic          WriteEn_i,
  input  logic [DA-1:0] Waddr_i,
  input  logic [DW-1:0] DataIn_i,
  input  logic          FlagEn_i,
  input  logic          ZeroIn_i,
  output logic [DW-1:0] INPUTA_o,
  output logic [DW-1:0] INPUTB_o,
  output logic [OW-1:0] OP_o,
  output logic          Valid_o,
  output logic          ZeroFlag_o
);

  logic [DW-1:0] arr_a, arr_b;
  logic [DW-1:0] rd_a, rd_b;

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [OW-1:0] op_q, op_d;
  logic          valid_q, valid_d;
  logic          zero_q, zero_d;

  reg_array #(.DW(DW), .DA(DA)) u_reg_array (
    .Clk_i     (Clk_i),
    .Reset_i   (Reset_i),
    .WriteEn_i (WriteEn_i),
    .Waddr_i   (Waddr_i),
    .DataIn_i  (DataIn_i),
    .RaddrA_i  (RaddrA_i),
    .RaddrB_i  (RaddrB_i),
    .RdataA_o  (arr_a),
    .RdataB_o  (arr_b)
  );

  // Forward the write-back value so a dependent op issued in the same cycle sees it.
  assign rd_a = (WriteEn_i && (Waddr_i == RaddrA_i)) ? DataIn_i : arr_a;
  assign rd_b = (WriteEn_i && (Waddr_i == RaddrB_i)) ? DataIn_i : arr_b;

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    if (Flush_i) begin
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      valid_d = 1'b0;
    end else if (!Stall_i) begin
      // Held operands are deliberately not re-read while stalled.
      a_d     = rd_a;
      b_d     = rd_b;
      op_d    = OpIn_i;
      valid_d = InValid_i;
    end
    if (FlagEn_i) begin
      zero_d = ZeroIn_i;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
    end
  end

  assign INPUTA_o   = a_q;
  assign INPUTB_o   = b_q;
  assign OP_o       = op_q;
  assign Valid_o    = valid_q;
  assign ZeroFlag_o = zero_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: reset, read latency, bypass, stall/flush, flag, full sweep.
module tb_operand_stage;
  import cpu_defs::*;

  logic           clk;
  logic           rst;
  logic           stall, flush, in_valid;
  logic [AW-1:0]  raddr_a, raddr_b, waddr;
  logic [OPW-1:0] op_in;
  logic           wen;
  logic [W-1:0]   data_in;
  logic           flag_en, zero_in;
  logic [W-1:0]   inputa, inputb;
  logic [OPW-1:0] op;
  logic           valid, zero_flag;

  int n_checks = 0;
  int n_fails  = 0;

  operand_stage dut (
    .Clk_i      (clk),
    .Reset_i    (rst),
    .Stall_i    (stall),
    .Flush_i    (flush),
    .InValid_i  (in_valid),
    .RaddrA_i   (raddr_a),
    .RaddrB_i   (raddr_b),
    .OpIn_i     (op_in),
    .WriteEn_i  (wen),
    .Waddr_i    (waddr),
    .DataIn_i   (data_in),
    .FlagEn_i   (flag_en),
    .ZeroIn_i   (zero_in),
    .INPUTA_o   (inputa),
    .INPUTB_o   (inputb),
    .OP_o       (op),
    .Valid_o    (valid),
    .ZeroFlag_o (zero_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_latch(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic [OPW-1:0] eop, input logic ev);
    chk({tag, ".A"}, 32'(inputa), 32'(ea));
    chk({tag, ".B"}, 32'(inputb), 32'(eb));
    chk({tag, ".OP"}, 32'(op), 32'(eop));
    chk({tag, ".V"}, 32'(valid), 32'(ev));
    $display("%0t %s: A=%0h B=%0h OP=%0h V=%0b Z=%0b", $time, tag, inputa, inputb, op, valid, zero_flag);
  endtask

  initial begin
    rst = 1'b1; stall = 0; flush = 0; in_valid = 0;
    raddr_a = 0; raddr_b = 0; waddr = 0; op_in = 0;
    wen = 0; data_in = 0; flag_en = 0; zero_in = 0;
    #2;
    chk_latch("reset", 8'h00, 8'h00, 3'b000, 1'b0);
    chk("reset.Z", 32'(zero_flag), 32'd0);
    step();
    rst = 1'b0;

    // 1: reset mid-run clears latch, flag and the array
    wen = 1; waddr = 3; data_in = 8'hA5;
    step();
    wen = 0; raddr_a = 3; raddr_b = 3; op_in = 3'b101; in_valid = 1; flag_en = 1; zero_in = 1;
    step();
    chk_latch("pre_reset", 8'hA5, 8'hA5, 3'b101, 1'b1);
    chk("pre_reset.Z", 32'(zero_flag), 32'd1);
    flag_en = 0; zero_in = 0;
    #1 rst = 1'b1;
    #1;
    chk_latch("async_reset", 8'h00, 8'h00, 3'b000, 1'b0);
    chk("async_reset.Z", 32'(zero_flag), 32'd0);
    #1 rst = 1'b0;
    step();
    chk_latch("read_R3_after_reset", 8'h00, 8'h00, 3'b101, 1'b1);

    // 2: basic read, one-cycle latency
    in_valid = 0;
    wen = 1; waddr = 1; data_in = 8'h2D;
    step();
    waddr = 2; data_in = 8'hB4;
    step();
    wen = 0; raddr_a = 1; raddr_b = 2; op_in = ALU_NOR; in_valid = 1;
    step();
    chk_latch("basic_read", 8'h2D, 8'hB4, 3'b011, 1'b1);

    // 3: write-through bypass on both ports
    wen = 1; waddr = 4; data_in = 8'h11;
    step();
    waddr = 4; data_in = 8'h5C; raddr_a = 4; raddr_b = 4; op_in = ALU_ADD;
    step();
    chk_latch("bypass", 8'h5C, 8'h5C, 3'b100, 1'b1);
    wen = 0; raddr_b = 2;
    step();
    chk_latch("bypass_stored", 8'h5C, 8'hB4, 3'b100, 1'b1);

    // 4: stall holds latch while writes continue, then flush beats stall
    raddr_a = 1; raddr_b = 2; op_in = ALU_NOR; in_valid = 1;
    step();
    chk_latch("stall_load", 8'h2D, 8'hB4, 3'b011, 1'b1);
    stall = 1; raddr_a = 4; op_in = ALU_SHIFT; in_valid = 0;
    wen = 1; waddr = 1; data_in = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_latch($sformatf("stall_hold%0d", i), 8'h2D, 8'hB4, 3'b011, 1'b1);
    end
    wen = 0; stall = 0; raddr_a = 1; op_in = ALU_BNEG; in_valid = 1;
    step();
    chk_latch("write_during_stall", 8'h77, 8'hB4, 3'b010, 1'b1);
    stall = 1; flush = 1;
    step();
    chk_latch("flush_over_stall", 8'h00, 8'h00, 3'b000, 1'b0);
    stall = 0; flush = 0; raddr_a = 2; raddr_b = 1; op_in = 3'b110; in_valid = 0;
    step();
    chk_latch("invalid_load", 8'hB4, 8'h77, 3'b110, 1'b0);

    // 5: zero flag capture/hold, independent of flush
    flag_en = 1; zero_in = 1;
    step();
    chk("flag_set", 32'(zero_flag), 32'd1);
    flag_en = 0; zero_in = 0;
    step();
    chk("flag_hold", 32'(zero_flag), 32'd1);
    flag_en = 1; zero_in = 0;
    step();
    chk("flag_clear", 32'(zero_flag), 32'd0);
    flag_en = 1; zero_in = 1; flush = 1;
    step();
    chk("flag_with_flush", 32'(zero_flag), 32'd1);
    chk("flag_with_flush.V", 32'(valid), 32'd0);
    flag_en = 0; zero_in = 0; flush = 0;

    // 6: full sweep of all entries
    wen = 1;
    for (int i = 0; i < 8; i++) begin
      waddr = AW'(i); data_in = 8'h10 + 8'(i);
      step();
    end
    wen = 0; in_valid = 1; op_in = ALU_ADD;
    for (int i = 0; i < 8; i++) begin
      raddr_a = AW'(i); raddr_b = AW'(7 - i);
      step();
      chk_latch($sformatf("sweep%0d", i), 8'h10 + 8'(i), 8'h17 - 8'(i), 3'b100, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
